// File: rtl/ram_access_ctrl.sv
`timescale 1ns/1ps
// ram_access_ctrl
// ---------------
// CPU-side initiator for a halfword-wide data RAM that has an active-low
// write enable, writes on posedge and reads combinationally. The controller
// takes one 32-bit load/store request at a time. It breaks the request into
// the 16-bit RAM accesses it needs, and then reports completion with a
// one-cycle response pulse.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   req_*           request handshake (valid/ready), direction, size,
//                   signedness, byte address and right-aligned store data
//   rsp_valid       one-cycle completion pulse
//   rsp_rdata       load result (0 for stores/errors), valid with rsp_valid
//   rsp_err         misaligned access or illegal size, valid with rsp_valid
//   ram_write_n     RAM write enable, low = write
//   ram_addr        RAM halfword address
//   ram_data_in     RAM write data
//   ram_data_out    RAM read data (combinational from ram_addr)
module ram_access_ctrl #(
    parameter int RAM_AW = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [RAM_AW:0]   req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              ram_write_n,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [15:0]       ram_data_in,
    input  logic [15:0]       ram_data_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_LO,
        S_RD_HI,
        S_RMW_RD,
        S_WR_LO,
        S_WR_HI,
        S_RESP
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [RAM_AW:0]   addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [15:0]       lo_q, lo_d;
    logic [15:0]       hi_q, hi_d;
    logic              err_q, err_d;

    logic              req_bad;
    logic [RAM_AW-1:0] hidx;
    logic [RAM_AW-1:0] hidx_p1;
    logic              write_n_c;
    logic [7:0]        byte_sel;
    logic [31:0]       load_result;

    // Size 11 and any misaligned half/word are rejected before touching RAM.
    always_comb begin
        req_bad = 1'b0;
        case (req_size)
            SZ_BYTE: req_bad = 1'b0;
            SZ_HALF: req_bad = req_addr[0];
            SZ_WORD: req_bad = |req_addr[1:0];
            default: req_bad = 1'b1;
        endcase
    end

    // An aligned word always has an even halfword index, so H+1 never wraps.
    assign hidx    = addr_q[RAM_AW:1];
    assign hidx_p1 = hidx + RAM_AW'(1);

    // Load result formatting from the captured halfword(s).
    assign byte_sel = addr_q[0] ? lo_q[15:8] : lo_q[7:0];
    always_comb begin
        load_result = 32'h0;
        case (size_q)
            SZ_WORD: load_result = {hi_q, lo_q};
            SZ_HALF: load_result = uns_q ? {16'h0, lo_q} : {{16{lo_q[15]}}, lo_q};
            SZ_BYTE: load_result = uns_q ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            default: load_result = 32'h0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        uns_d       = uns_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        err_d       = err_q;

        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        rsp_rdata   = 32'h0;
        rsp_err     = 1'b0;
        write_n_c   = 1'b1;
        ram_addr    = '0;
        ram_data_in = 16'h0;

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    lo_d    = 16'h0;
                    hi_d    = 16'h0;
                    err_d   = req_bad;
                    if (req_bad)
                        state_d = S_RESP;
                    else if (!req_we)
                        state_d = S_RD_LO;
                    else if (req_size == SZ_BYTE)
                        state_d = S_RMW_RD;
                    else
                        state_d = S_WR_LO;
                end
            end
            S_RD_LO: begin
                ram_addr = hidx;
                lo_d     = ram_data_out;
                state_d  = (size_q == SZ_WORD) ? S_RD_HI : S_RESP;
            end
            S_RD_HI: begin
                ram_addr = hidx_p1;
                hi_d     = ram_data_out;
                state_d  = S_RESP;
            end
            S_RMW_RD: begin
                ram_addr = hidx;
                lo_d     = ram_data_out;
                state_d  = S_WR_LO;
            end
            S_WR_LO: begin
                ram_addr  = hidx;
                write_n_c = 1'b0;
                if (size_q == SZ_BYTE)
                    // Replace only the addressed byte lane of the old halfword.
                    ram_data_in = addr_q[0] ? {wdata_q[7:0], lo_q[7:0]}
                                            : {lo_q[15:8], wdata_q[7:0]};
                else
                    ram_data_in = wdata_q[15:0];
                state_d = (size_q == SZ_WORD) ? S_WR_HI : S_RESP;
            end
            S_WR_HI: begin
                ram_addr    = hidx_p1;
                write_n_c   = 1'b0;
                ram_data_in = wdata_q[31:16];
                state_d     = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                rsp_rdata = (err_q || we_q) ? 32'h0 : load_result;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The state register only clears on the reset edge. Gating the strobe
    // with rst therefore keeps a reset that lands in a write state from
    // committing that write.
    assign ram_write_n = rst | write_n_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            lo_q    <= 16'h0;
            hi_q    <= 16'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_ram_access_ctrl.sv
`timescale 1ns/1ps
module tb_ram_access_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [10:0] req_addr = 11'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        ram_write_n;
    logic [9:0]  ram_addr;
    logic [15:0] ram_data_in;
    logic [15:0] ram_data_out;

    int n_cmp = 0;
    int n_bad = 0;
    int wr_count = 0;

    logic [15:0] mem [1024];

    always #5 clk = ~clk;

    ram_access_ctrl #(.RAM_AW(10)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .ram_write_n  (ram_write_n),
        .ram_addr     (ram_addr),
        .ram_data_in  (ram_data_in),
        .ram_data_out (ram_data_out)
    );

    // Behavioural 1024x16 RAM: posedge write when write_n is low, combinational read.
    assign ram_data_out = mem[ram_addr];
    always @(posedge clk) begin
        if (!ram_write_n) begin
            mem[ram_addr] <= ram_data_in;
            wr_count      <= wr_count + 1;
        end
    end

    // Issue one request and wait (bounded) for its response pulse.
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [10:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1;
        // Scramble the fields after acceptance; the DUT must not look at them.
        req_valid = 1'b0; req_we = ~we; req_size = ~size; req_unsigned = ~uns;
        req_addr = ~addr; req_wdata = 32'h5A5A5A5A;
        lat = 0; rdata = 32'h0; err = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = i; rdata = rsp_rdata; err = rsp_err;
                break;
            end
        end
        if (lat == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL timeout addr=%h: no rsp_valid within 10 cycles", addr);
        end
        $display("req we=%0b size=%0d uns=%0b addr=%h wdata=%h -> rdata=%h err=%0b lat=%0d",
                 we, size, uns, addr, wdata, rdata, err, lat);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1)    begin n_bad++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0)    begin n_bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        n_cmp++; if (rsp_rdata !== 32'h0)   begin n_bad++; $display("FAIL reset_rdata got=%h exp=0", rsp_rdata); end
        n_cmp++; if (rsp_err !== 1'b0)      begin n_bad++; $display("FAIL reset_err got=%b exp=0", rsp_err); end
        n_cmp++; if (ram_write_n !== 1'b1)  begin n_bad++; $display("FAIL reset_write_n got=%b exp=1", ram_write_n); end
        n_cmp++; if (ram_addr !== 10'h0)    begin n_bad++; $display("FAIL reset_ram_addr got=%h exp=0", ram_addr); end
        n_cmp++; if (ram_data_in !== 16'h0) begin n_bad++; $display("FAIL reset_ram_data_in got=%h exp=0", ram_data_in); end
        rst = 1'b0;
        $display("reset: ready=%b write_n=%b", req_ready, ram_write_n);
    endtask

    task automatic test_word();
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 2'b10, 1'b0, 11'h008, 32'hDEADBEEF, rd, er, lat);
        n_cmp++; if (lat != 3)            begin n_bad++; $display("FAIL word_st_lat got=%0d exp=3", lat); end
        n_cmp++; if (er !== 1'b0)         begin n_bad++; $display("FAIL word_st_err got=%b exp=0", er); end
        n_cmp++; if (rd !== 32'h0)        begin n_bad++; $display("FAIL word_st_rdata got=%h exp=0", rd); end
        n_cmp++; if (mem[4] !== 16'hBEEF) begin n_bad++; $display("FAIL word_st_ram4 got=%h exp=beef", mem[4]); end
        n_cmp++; if (mem[5] !== 16'hDEAD) begin n_bad++; $display("FAIL word_st_ram5 got=%h exp=dead", mem[5]); end
        do_req(1'b0, 2'b10, 1'b0, 11'h008, 32'h0, rd, er, lat);
        n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL word_ld_rdata got=%h exp=deadbeef", rd); end
        n_cmp++; if (lat != 3)            begin n_bad++; $display("FAIL word_ld_lat got=%0d exp=3", lat); end
        n_cmp++; if (er !== 1'b0)         begin n_bad++; $display("FAIL word_ld_err got=%b exp=0", er); end
        // Response fields must fall back to zero once the pulse ends.
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0)
            begin n_bad++; $display("FAIL word_post_rsp got valid=%b rdata=%h exp valid=0 rdata=0", rsp_valid, rsp_rdata); end
    endtask

    task automatic test_byte_rmw();
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 2'b01, 1'b0, 11'h004, 32'h00001234, rd, er, lat);
        n_cmp++; if (lat != 2)            begin n_bad++; $display("FAIL half_st_lat got=%0d exp=2", lat); end
        n_cmp++; if (mem[2] !== 16'h1234) begin n_bad++; $display("FAIL half_st_ram2 got=%h exp=1234", mem[2]); end
        do_req(1'b1, 2'b00, 1'b0, 11'h005, 32'h000000AB, rd, er, lat);
        n_cmp++; if (lat != 3)            begin n_bad++; $display("FAIL byte_st_lat got=%0d exp=3", lat); end
        n_cmp++; if (mem[2] !== 16'hAB34) begin n_bad++; $display("FAIL byte_st_ram2 got=%h exp=ab34", mem[2]); end
        do_req(1'b0, 2'b00, 1'b0, 11'h005, 32'h0, rd, er, lat);
        n_cmp++; if (rd !== 32'hFFFFFFAB) begin n_bad++; $display("FAIL byte_ld_s got=%h exp=ffffffab", rd); end
        n_cmp++; if (lat != 2)            begin n_bad++; $display("FAIL byte_ld_lat got=%0d exp=2", lat); end
        do_req(1'b0, 2'b00, 1'b1, 11'h005, 32'h0, rd, er, lat);
        n_cmp++; if (rd !== 32'h000000AB) begin n_bad++; $display("FAIL byte_ld_u got=%h exp=000000ab", rd); end
        do_req(1'b0, 2'b00, 1'b0, 11'h004, 32'h0, rd, er, lat);
        n_cmp++; if (rd !== 32'h00000034) begin n_bad++; $display("FAIL byte_ld_lo got=%h exp=00000034", rd); end
        // Low-lane byte store leaves the upper byte intact.
        do_req(1'b1, 2'b00, 1'b0, 11'h004, 32'hFFFFFF9C, rd, er, lat);
        n_cmp++; if (mem[2] !== 16'hAB9C) begin n_bad++; $display("FAIL byte_st_lo_ram2 got=%h exp=ab9c", mem[2]); end
    endtask

    task automatic test_half_load();
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 2'b01, 1'b0, 11'h006, 32'hFFFF8001, rd, er, lat);
        n_cmp++; if (mem[3] !== 16'h8001) begin n_bad++; $display("FAIL half_st_ram3 got=%h exp=8001", mem[3]); end
        do_req(1'b0, 2'b01, 1'b0, 11'h006, 32'h0, rd, er, lat);
        n_cmp++; if (rd !== 32'hFFFF8001) begin n_bad++; $display("FAIL half_ld_s got=%h exp=ffff8001", rd); end
        n_cmp++; if (lat != 2)            begin n_bad++; $display("FAIL half_ld_lat got=%0d exp=2", lat); end
        do_req(1'b0, 2'b01, 1'b1, 11'h006, 32'h0, rd, er, lat);
        n_cmp++; if (rd !== 32'h00008001) begin n_bad++; $display("FAIL half_ld_u got=%h exp=00008001", rd); end
    endtask

    task automatic test_misaligned();
        logic [31:0] rd; logic er; int lat; int wc0; logic [15:0] m1;
        wc0 = wr_count;
        m1  = mem[1];
        do_req(1'b0, 2'b10, 1'b0, 11'h006, 32'h0, rd, er, lat);
        n_cmp++; if (er !== 1'b1)  begin n_bad++; $display("FAIL mis_word_err got=%b exp=1", er); end
        n_cmp++; if (lat != 1)     begin n_bad++; $display("FAIL mis_word_lat got=%0d exp=1", lat); end
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL mis_word_rdata got=%h exp=0", rd); end
        do_req(1'b1, 2'b01, 1'b0, 11'h003, 32'h0000CAFE, rd, er, lat);
        n_cmp++; if (er !== 1'b1)  begin n_bad++; $display("FAIL mis_half_err got=%b exp=1", er); end
        n_cmp++; if (lat != 1)     begin n_bad++; $display("FAIL mis_half_lat got=%0d exp=1", lat); end
        do_req(1'b1, 2'b11, 1'b0, 11'h000, 32'h12345678, rd, er, lat);
        n_cmp++; if (er !== 1'b1)  begin n_bad++; $display("FAIL size11_err got=%b exp=1", er); end
        n_cmp++; if (wr_count != wc0) begin n_bad++; $display("FAIL mis_no_write got=%0d writes exp=0", wr_count - wc0); end
        n_cmp++; if (mem[1] !== m1)   begin n_bad++; $display("FAIL mis_ram1 got=%h exp=%h", mem[1], m1); end
        @(negedge clk);
        n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL mis_err_clear got=%b exp=0", rsp_err); end
    endtask

    task automatic test_reset_midop();
        logic [31:0] rd; logic er; int lat; logic seen;
        do_req(1'b1, 2'b10, 1'b0, 11'h010, 32'h5555AAAA, rd, er, lat);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 11'h010; req_wdata = 32'h11112222;
        @(posedge clk); #1;              // accepted, now in WR_LO
        req_valid = 1'b0;
        @(posedge clk); #1;              // WR_LO write done, now in WR_HI
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (ram_write_n !== 1'b1) begin n_bad++; $display("FAIL midop_write_n got=%b exp=1", ram_write_n); end
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0)        begin n_bad++; $display("FAIL midop_no_rsp got=%b exp=0", seen); end
        n_cmp++; if (req_ready !== 1'b1)   begin n_bad++; $display("FAIL midop_ready got=%b exp=1", req_ready); end
        n_cmp++; if (mem[9] !== 16'h5555)  begin n_bad++; $display("FAIL midop_ram9 got=%h exp=5555", mem[9]); end
        n_cmp++; if (mem[8] !== 16'h2222)  begin n_bad++; $display("FAIL midop_ram8 got=%h exp=2222", mem[8]); end
        $display("reset mid-op: ram8=%h ram9=%h", mem[8], mem[9]);
        do_req(1'b0, 2'b10, 1'b0, 11'h010, 32'h0, rd, er, lat);
        n_cmp++; if (rd !== 32'h55552222)  begin n_bad++; $display("FAIL midop_reload got=%h exp=55552222", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 2'b01, 1'b0, 11'h00C, 32'h00007E57, rd, er, lat);
        do_req(1'b0, 2'b01, 1'b1, 11'h00C, 32'h0, rd, er, lat);
        n_cmp++; if (rd !== 32'h00007E57) begin n_bad++; $display("FAIL b2b_half got=%h exp=00007e57", rd); end
        do_req(1'b0, 2'b00, 1'b0, 11'h00D, 32'h0, rd, er, lat);
        n_cmp++; if (rd !== 32'h0000007E) begin n_bad++; $display("FAIL b2b_byte_hi got=%h exp=0000007e", rd); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte_rmw();
        test_half_load();
        test_misaligned();
        test_reset_midop();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
